// File: rtl/instruction_fetch_unit_pkg.sv
// Shared opcode values, instruction field positions and fetch FSM states.
// Imported by the fetch unit and any stage that needs to decode the word.
package instruction_fetch_unit_pkg;

   localparam logic [3:0] OpNop = 4'h0;
   localparam logic [3:0] OpSto = 4'h1;
   localparam logic [3:0] OpAdd = 4'h2;
   localparam logic [3:0] OpSub = 4'h3;
   localparam logic [3:0] OpBle = 4'h4;
   localparam logic [3:0] OpJmp = 4'h5;
   localparam logic [3:0] OpLed = 4'h6;

   localparam int unsigned InsnOpMsb  = 27;
   localparam int unsigned InsnOpLsb  = 24;
   localparam int unsigned InsnTgtMsb = 23;
   localparam int unsigned InsnTgtLsb = 16;

   typedef enum logic {
      StBoot,
      StRun
   } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, addresses the combinational instruction ROM and loads
// the IF/ID register, handling stall, execute-stage branch redirect and fetch-side JMP.
module instruction_fetch_unit
   import instruction_fetch_unit_pkg::*;
#(
   parameter int unsigned AddrW             = 16,
   parameter int unsigned InsnW             = 28,
   parameter int unsigned TgtW              = 8,
   parameter logic [AddrW-1:0] ResetVector = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   output logic [AddrW-1:0] rom_address,
   input  logic [InsnW-1:0] rom_instruction,
   input  logic             stall,
   input  logic             branch_taken,
   input  logic [TgtW-1:0]  branch_target,
   output logic [InsnW-1:0] instruction,
   output logic [AddrW-1:0] pc,
   output logic             valid,
   output logic [15:0]      bubble_count
);

   fetch_state_e     state_q, state_d;
   logic [AddrW-1:0] pc_q, pc_d;
   logic [InsnW-1:0] insn_q, insn_d;
   logic [AddrW-1:0] ifid_pc_q, ifid_pc_d;
   logic             valid_q, valid_d;
   logic [15:0]      count_q, count_d;
   logic             bubble;
   logic [3:0]       fetched_op;
   logic [AddrW-1:0] jmp_target;
   logic             unused_fields;

   assign fetched_op    = rom_instruction[InsnOpMsb:InsnOpLsb];
   assign jmp_target    = AddrW'(rom_instruction[InsnTgtMsb:InsnTgtLsb]);
   assign unused_fields = ^rom_instruction[InsnTgtLsb-1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StBoot;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StBoot:  state_d = StRun;
         StRun:   state_d = StRun;
         default: state_d = StBoot;
      endcase
   end

   // Branch beats stall; a stall freezes PC and IF/ID and counts nothing.
   always_comb begin
      pc_d      = pc_q;
      insn_d    = insn_q;
      ifid_pc_d = ifid_pc_q;
      valid_d   = valid_q;
      bubble    = 1'b0;
      unique case (state_q)
         StBoot: bubble = 1'b1;
         StRun: begin
            if (branch_taken) begin
               pc_d   = AddrW'(branch_target);
               bubble = 1'b1;
            end else if (!stall) begin
               if (fetched_op == OpJmp) begin
                  pc_d   = jmp_target;
                  bubble = 1'b1;
               end else begin
                  insn_d    = rom_instruction;
                  ifid_pc_d = pc_q;
                  valid_d   = 1'b1;
                  pc_d      = pc_q + 1'b1;
               end
            end
         end
         default: bubble = 1'b1;
      endcase
      if (bubble) begin
         insn_d    = '0;
         ifid_pc_d = '0;
         valid_d   = 1'b0;
      end
      count_d = (bubble && count_q != 16'hFFFF) ? count_q + 16'd1 : count_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q      <= ResetVector;
         insn_q    <= '0;
         ifid_pc_q <= '0;
         valid_q   <= 1'b0;
         count_q   <= '0;
      end else begin
         pc_q      <= pc_d;
         insn_q    <= insn_d;
         ifid_pc_q <= ifid_pc_d;
         valid_q   <= valid_d;
         count_q   <= count_d;
      end
   end

   assign rom_address  = pc_q;
   assign instruction  = insn_q;
   assign pc           = ifid_pc_q;
   assign valid        = valid_q;
   assign bubble_count = count_q;

endmodule
